// File: rtl/phase_clock_gen.sv
// ============================================================================
//  Module      : phase_clock_gen
//  Description : One-hot multi-phase clock-enable generator with per-phase
//                stretch, graceful cycle-boundary halt, cycle-start pulse and
//                completed-cycle counter. Optional single-cycle stepping from
//                HALTED is enabled by defining PHASE_CLOCK_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_clock_gen #(
    parameter int NUM_PHASES = 3,
    parameter int STRETCH_W  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            halt,
`ifdef PHASE_CLOCK_STEP_EN
    input  logic                            step,
`endif
    input  logic [NUM_PHASES*STRETCH_W-1:0] stretch,
    output logic [NUM_PHASES-1:0]           phase_out,
    output logic [$clog2(NUM_PHASES)-1:0]   phase_idx,
    output logic                            cycle_start,
    output logic                            halted,
    output logic [CNT_W-1:0]                cycle_count
);

    localparam int                IDX_W    = $clog2(NUM_PHASES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [STRETCH_W-1:0]   dwell, dwell_n;
    logic [STRETCH_W-1:0]   cur_len, cur_len_n;
    logic                   single, single_n;
    logic [NUM_PHASES-1:0]  phase_out_n;
    logic [IDX_W-1:0]       phase_idx_n;
    logic                   cycle_start_n;
    logic                   halted_n;
    logic [CNT_W-1:0]       cycle_count_n;

    logic                   enter;
    logic [IDX_W-1:0]       enter_idx;
    logic                   go_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            dwell       <= '0;
            cur_len     <= '0;
            single      <= 1'b0;
            phase_out   <= '0;
            phase_idx   <= '0;
            cycle_start <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            dwell       <= dwell_n;
            cur_len     <= cur_len_n;
            single      <= single_n;
            phase_out   <= phase_out_n;
            phase_idx   <= phase_idx_n;
            cycle_start <= cycle_start_n;
            halted      <= halted_n;
            cycle_count <= cycle_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        dwell_n       = dwell;
        cur_len_n     = cur_len;
        single_n      = single;
        phase_out_n   = phase_out;
        phase_idx_n   = phase_idx;
        cycle_start_n = 1'b0;
        halted_n      = halted;
        cycle_count_n = cycle_count;
        enter         = 1'b0;
        enter_idx     = '0;
        go_halt       = 1'b0;

        case (state)
            RUN: begin
                // No phase active in RUN only happens on the first edge after reset.
                if (phase_out == '0) begin
                    if (halt) go_halt = 1'b1;
                    else      enter   = 1'b1;
                end else if (dwell == cur_len) begin
                    if (phase_idx != LAST_IDX) begin
                        enter     = 1'b1;
                        enter_idx = phase_idx + IDX_W'(1);
                    end else begin
                        cycle_count_n = cycle_count + CNT_W'(1);
                        if (halt || single) go_halt = 1'b1;
                        else                enter   = 1'b1;
                    end
                end else begin
                    dwell_n = dwell + STRETCH_W'(1);
                end
            end
            HALTED: begin
                if (!halt) begin
                    enter    = 1'b1;
                    single_n = 1'b0;
                end
`ifdef PHASE_CLOCK_STEP_EN
                else if (step) begin
                    enter    = 1'b1;
                    single_n = 1'b1;
                end
`endif
            end
            default: go_halt = 1'b1;
        endcase

        if (enter) begin
            state_n       = RUN;
            phase_out_n   = NUM_PHASES'(1) << enter_idx;
            phase_idx_n   = enter_idx;
            cycle_start_n = (enter_idx == '0);
            halted_n      = 1'b0;
            dwell_n       = '0;
            cur_len_n     = stretch[int'(enter_idx)*STRETCH_W +: STRETCH_W];
        end
        if (go_halt) begin
            state_n     = HALTED;
            phase_out_n = '0;
            phase_idx_n = '0;
            halted_n    = 1'b1;
            single_n    = 1'b0;
        end
    end

endmodule

`default_nettype wire
